// File: rtl/pe_sched_pkg.sv
// Shared definitions for the priority-encoder request scheduler.
//   state_t   : scheduler FSM states (IDLE, ISSUE, DONE)
//   N_REQ     : request vector width (fixed at 16 for this tile)
//   IDX_W     : grant index width
//   NONE_CODE : index value presented when no grant is valid
package pe_sched_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] NONE_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pe_prio_enc16.sv
// Combinational 16-to-8 highest-index priority encoder.
//   req    [15:0] : input vector, bit 15 has the highest priority
//   idx    [7:0]  : index of the highest set bit, NONE_CODE when req is zero
//   onehot [15:0] : one-hot of the selected bit, zero when req is zero
module pe_prio_enc16
  import pe_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // Ascending scan: the last set bit visited is the highest, so it wins.
  always_comb begin
    idx    = NONE_CODE;
    onehot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        idx    = IDX_W'(i);
        onehot = N_REQ'(1) << i;
      end
    end
  end

endmodule

// File: rtl/pe_request_scheduler.sv
// Batch scheduler that drains a captured request vector through the shared
// priority encoder, one grant per accepted handshake, highest index first.
//   clk, rst_n      : clock, synchronous active-low reset
//   load_i, req_i   : capture request vector {A,B} (sampled in IDLE only)
//   abort_i         : terminate the current batch (honoured in ISSUE only)
//   grant_ready_i   : consumer accepts the presented grant
//   grant_valid_o   : a grant is presented
//   grant_idx_o     : grant index, NONE_CODE when no grant is valid
//   grant_onehot_o  : grant one-hot, zero when no grant is valid
//   pending_o       : requests not yet granted
//   grant_cnt_o     : grants accepted in the current batch (0..16)
//   busy_o          : high in ISSUE and DONE
//   done_o          : one-cycle pulse at batch end
module pe_request_scheduler
  import pe_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             abort_i,
  input  logic             grant_ready_i,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic [N_REQ-1:0] grant_onehot_o,
  output logic [N_REQ-1:0] pending_o,
  output logic [4:0]       grant_cnt_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state;
  logic [N_REQ-1:0] pending;
  logic [4:0]       grant_cnt;
  logic [IDX_W-1:0] enc_idx;
  logic [N_REQ-1:0] enc_onehot;
  logic             grant_valid;
  logic             handshake;
  logic [N_REQ-1:0] pending_cleared;

  pe_prio_enc16 u_enc (
    .req    (pending),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  always_comb begin
    grant_valid     = (state == ISSUE);
    handshake       = grant_valid & grant_ready_i;
    pending_cleared = pending & ~enc_onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      grant_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_i) begin
            pending   <= req_i;
            grant_cnt <= '0;
            state     <= (req_i != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          // Abort wins over a simultaneous handshake: the grant is not counted.
          if (abort_i) begin
            pending <= '0;
            state   <= DONE;
          end else if (handshake) begin
            pending   <= pending_cleared;
            grant_cnt <= grant_cnt + 5'd1;
            if (pending_cleared == '0) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    grant_valid_o  = grant_valid;
    grant_idx_o    = grant_valid ? enc_idx : NONE_CODE;
    grant_onehot_o = grant_valid ? enc_onehot : '0;
    pending_o      = pending;
    grant_cnt_o    = grant_cnt;
    busy_o         = (state == ISSUE) || (state == DONE);
    done_o         = (state == DONE);
  end

endmodule

// File: tb/tb_pe_request_scheduler.sv
// Directed bench for pe_request_scheduler. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Each comparison checks a packed
// snapshot {valid, idx, onehot, pending, cnt, busy, done}.
module tb_pe_request_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i;
  logic [15:0] req_i;
  logic        abort_i;
  logic        grant_ready_i;
  logic        grant_valid_o;
  logic [7:0]  grant_idx_o;
  logic [15:0] grant_onehot_o;
  logic [15:0] pending_o;
  logic [4:0]  grant_cnt_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  pe_request_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (load_i),
    .req_i          (req_i),
    .abort_i        (abort_i),
    .grant_ready_i  (grant_ready_i),
    .grant_valid_o  (grant_valid_o),
    .grant_idx_o    (grant_idx_o),
    .grant_onehot_o (grant_onehot_o),
    .pending_o      (pending_o),
    .grant_cnt_o    (grant_cnt_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] snap();
    return {grant_valid_o, grant_idx_o, grant_onehot_o, pending_o,
            grant_cnt_o, busy_o, done_o};
  endfunction

  function automatic logic [47:0] mk(input logic v, input logic [7:0] idx,
                                     input logic [15:0] oh, input logic [15:0] pend,
                                     input logic [4:0] cnt, input logic busy,
                                     input logic done);
    return {v, idx, oh, pend, cnt, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [47:0] exp;
    rst_n = 1'b0; load_i = 1'b0; req_i = '0; abort_i = 1'b0; grant_ready_i = 1'b0;
    tick(); tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", snap(), exp);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL reset_idle_hold got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_normal();
    logic [47:0] exp;
    load_i = 1'b1; req_i = 16'h8001; grant_ready_i = 1'b1;
    tick(); load_i = 1'b0; req_i = '0;
    exp = mk(1'b1, 8'd15, 16'h8000, 16'h8001, 5'd0, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL normal_t1 got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b1, 8'd0, 16'h0001, 16'h0001, 5'd1, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL normal_t2 got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd2, 1'b1, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL normal_done got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd2, 1'b0, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL normal_idle_cnt_hold got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_empty();
    logic [47:0] exp;
    load_i = 1'b1; req_i = 16'h0000; grant_ready_i = 1'b1;
    tick(); load_i = 1'b0;
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL empty_done got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL empty_idle got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] exp;
    load_i = 1'b1; req_i = 16'h0430; grant_ready_i = 1'b0;
    exp = mk(1'b1, 8'd10, 16'h0400, 16'h0430, 5'd0, 1'b1, 1'b0);
    tick(); load_i = 1'b0; req_i = '0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (snap() !== exp) begin
        failures++; $display("FAIL backpressure_hold%0d got=%h exp=%h", c, snap(), exp);
      end
      if (c < 2) tick();
    end
    grant_ready_i = 1'b1;
    tick();
    exp = mk(1'b1, 8'd5, 16'h0020, 16'h0030, 5'd1, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL backpressure_idx5 got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b1, 8'd4, 16'h0010, 16'h0010, 5'd2, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL backpressure_idx4 got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd3, 1'b1, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL backpressure_done got=%h exp=%h", snap(), exp);
    end
    tick();
  endtask

  task automatic test_full_vector();
    logic [47:0] exp;
    logic [15:0] pend;
    load_i = 1'b1; req_i = 16'hFFFF; grant_ready_i = 1'b1;
    pend = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      tick(); load_i = 1'b0; req_i = '0;
      exp = mk(1'b1, 8'(15 - i), 16'h8000 >> i, pend, 5'(i), 1'b1, 1'b0);
      checks++;
      if (snap() !== exp) begin
        failures++; $display("FAIL full_grant%0d got=%h exp=%h", i, snap(), exp);
      end
      pend = pend >> 1;
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd16, 1'b1, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL full_done got=%h exp=%h", snap(), exp);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [47:0] exp;
    load_i = 1'b1; req_i = 16'h00F0; grant_ready_i = 1'b1;
    tick();
    // Load during ISSUE with a different vector must have no effect.
    req_i = 16'hFFFF;
    exp = mk(1'b1, 8'd7, 16'h0080, 16'h00F0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL abort_first got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b1, 8'd6, 16'h0040, 16'h0070, 5'd1, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL abort_load_ignored got=%h exp=%h", snap(), exp);
    end
    load_i = 1'b0; req_i = '0; abort_i = 1'b1;
    tick(); abort_i = 1'b0;
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd1, 1'b1, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL abort_done got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd1, 1'b0, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL abort_idle got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_reset_mid_batch();
    logic [47:0] exp;
    load_i = 1'b1; req_i = 16'h0F00; grant_ready_i = 1'b1;
    tick(); load_i = 1'b0; req_i = '0;
    exp = mk(1'b1, 8'd11, 16'h0800, 16'h0F00, 5'd0, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL midreset_first got=%h exp=%h", snap(), exp);
    end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL midreset_state got=%h exp=%h", snap(), exp);
    end
    tick();
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL midreset_no_done got=%h exp=%h", snap(), exp);
    end
    load_i = 1'b1; req_i = 16'h0003;
    tick(); load_i = 1'b0; req_i = '0;
    exp = mk(1'b1, 8'd1, 16'h0002, 16'h0003, 5'd0, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL midreset_reload1 got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b1, 8'd0, 16'h0001, 16'h0001, 5'd1, 1'b1, 1'b0);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL midreset_reload0 got=%h exp=%h", snap(), exp);
    end
    tick();
    exp = mk(1'b0, 8'hF0, 16'h0, 16'h0, 5'd2, 1'b1, 1'b1);
    checks++;
    if (snap() !== exp) begin
      failures++; $display("FAIL midreset_reload_done got=%h exp=%h", snap(), exp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_empty();
    test_backpressure();
    test_full_vector();
    test_abort();
    test_reset_mid_batch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
